// File: rtl/ntt_add_pkg.sv
// Shared definitions for the NTT wide modular adder datapath.
package ntt_add_pkg;

  localparam int unsigned WIDTH_DEFAULT = 128;

  typedef logic [WIDTH_DEFAULT-1:0] operand_t;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Number of register stages needed to cover all prefix levels.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/kogge_stone_level.sv
// One Kogge-Stone prefix level: combine each bit with the bit DIST below it.
module kogge_stone_level #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g_next,
  output logic [WIDTH-1:0] p_next
);

  // Bits below DIST have no partner at this level and pass through.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    if (i >= DIST) begin : g_comb
      assign g_next[i] = g[i] | (p[i] & g[i-DIST]);
      assign p_next[i] = p[i] & p[i-DIST];
    end else begin : g_pass
      assign g_next[i] = g[i];
      assign p_next[i] = p[i];
    end
  end

endmodule

// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry generator with a global-stall valid/ready pipeline.
module prefix_carry_pipe
  import ntt_add_pkg::*;
#(
  parameter int unsigned WIDTH            = WIDTH_DEFAULT,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] c_out,
  output logic             cout
);

  localparam int unsigned LOG2W      = clog2(WIDTH);
  localparam int unsigned LPS        = LEVELS_PER_STAGE;
  localparam int unsigned NUM_STAGES = num_stages(WIDTH, LPS);

  logic             advance;
  logic [WIDTH-1:0] pre_g;
  logic [WIDTH-1:0] pre_p;

  // Whole pipeline moves together whenever the output slot is free.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Generate/propagate, with cin folded into bit 0 generate.
  assign pre_p = a ^ b;
  assign pre_g = (a & b) | {{(WIDTH-1){1'b0}}, pre_p[0] & cin};

  // Prefix levels; the first level of each stage reads the previous stage register.
  for (genvar k = 0; k < LOG2W; k++) begin : gen_lvl
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_nxt;

    if (k == 0) begin : g_src
      assign g = pre_g;
      assign p = pre_p;
    end else if ((k % LPS) == 0) begin : g_src
      assign g = gen_stage[k/LPS-1].g_q;
      assign p = gen_stage[k/LPS-1].g_pg.pg_q;
    end else begin : g_src
      assign g = gen_lvl[k-1].g_nxt;
      assign p = gen_lvl[k-1].g_mid.p_nxt;
    end

    // Group propagate of the final level has no consumer.
    if (k == LOG2W-1) begin : g_last
      logic [WIDTH-1:0] p_unused;
      kogge_stone_level #(.WIDTH(WIDTH), .DIST(32'd1 << k)) u_level (
        .g      (g),
        .p      (p),
        .g_next (g_nxt),
        .p_next (p_unused)
      );
    end else begin : g_mid
      logic [WIDTH-1:0] p_nxt;
      kogge_stone_level #(.WIDTH(WIDTH), .DIST(32'd1 << k)) u_level (
        .g      (g),
        .p      (p),
        .g_next (g_nxt),
        .p_next (p_nxt)
      );
    end
  end

  // Stage registers: group G, original p, cin and valid; group P only where a later level needs it.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : gen_stage
    localparam int unsigned LAST_LVL = ((((s+1)*LPS) < LOG2W) ? ((s+1)*LPS) : LOG2W) - 1;

    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] p_q;
    logic             cin_q;
    logic             v_q;
    logic [WIDTH-1:0] p_d;
    logic             cin_d;
    logic             v_d;

    if (s == 0) begin : g_head
      assign p_d   = pre_p;
      assign cin_d = cin;
      assign v_d   = in_valid;
    end else begin : g_head
      assign p_d   = gen_stage[s-1].p_q;
      assign cin_d = gen_stage[s-1].cin_q;
      assign v_d   = gen_stage[s-1].v_q;
    end

    // Shift on advance, bubbles included; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        g_q   <= '0;
        p_q   <= '0;
        cin_q <= 1'b0;
        v_q   <= 1'b0;
      end else if (advance) begin
        g_q   <= gen_lvl[LAST_LVL].g_nxt;
        p_q   <= p_d;
        cin_q <= cin_d;
        v_q   <= v_d;
      end
    end

    if (s < NUM_STAGES-1) begin : g_pg
      logic [WIDTH-1:0] pg_q;

      // Group propagate carried into the next stage's levels.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pg_q <= '0;
        end else if (advance) begin
          pg_q <= gen_lvl[LAST_LVL].g_mid.p_nxt;
        end
      end
    end
  end

  // Outputs come straight from the last stage register.
  assign out_valid = gen_stage[NUM_STAGES-1].v_q;
  assign p_out     = gen_stage[NUM_STAGES-1].p_q;
  assign c_out     = {gen_stage[NUM_STAGES-1].g_q[WIDTH-2:0], gen_stage[NUM_STAGES-1].cin_q};
  assign cout      = gen_stage[NUM_STAGES-1].g_q[WIDTH-1];

endmodule
